// File: rtl/trd_pkg.sv
// Shared constants and types for the hardware thread scheduler.
// Holds the thread-count parameters, lock timeout limit and scheduler state encoding.
package trd_pkg;

    localparam int NUM_TRD = 8;
    localparam int TRD_W   = 3;
    localparam int QNT_W   = 4;
    localparam int LOCK_W  = 6;

    localparam logic [LOCK_W-1:0] ATOMIC_MAX = 6'd63;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LOCK = 2'd2
    } trd_sched_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set mask bit at offset+1 .. offset+7, then offset.
// With an empty mask the index falls back to the offset and found stays low.
module rr_pick
    import trd_pkg::*;
(
    input  logic [NUM_TRD-1:0] mask,
    input  logic [TRD_W-1:0]   offset,
    output logic [TRD_W-1:0]   index,
    output logic               found
);

    logic [TRD_W-1:0] cand;

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        index = offset;
        found = 1'b0;
        cand  = offset;
        // Scan farthest-first so the nearest candidate overwrites and wins; i = NUM_TRD wraps to offset.
        for (int i = NUM_TRD; i >= 1; i--) begin
            cand = offset + TRD_W'(i);
            if (mask[cand]) begin
                index = cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/trd_sched.sv
// Round-robin hardware thread scheduler with time-slice quantum, atomic lock and lock timeout.
// All state lives here; the search itself is delegated to rr_pick.
module trd_sched
    import trd_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_TRD-1:0] run_trd,
    input  logic               stall,
    input  logic               atomic,
    input  logic               yield,
    input  logic [QNT_W-1:0]   quantum,
    output logic [TRD_W-1:0]   cur_trd,
    output logic [TRD_W-1:0]   nxt_trd,
    output logic               cur_vld,
    output logic               switch_p,
    output logic               atomic_to
);

    trd_sched_state_t    state_q, state_d;
    logic [TRD_W-1:0]    cur_trd_q, cur_trd_d;
    logic [QNT_W-1:0]    qcnt_q, qcnt_d;
    logic [LOCK_W-1:0]   lock_cnt_q, lock_cnt_d;
    logic                cur_vld_q, cur_vld_d;
    logic                switch_p_q, switch_p_d;
    logic                atomic_to_q, atomic_to_d;

    logic [TRD_W-1:0]    pick_idx;
    logic                any_run;
    logic                cur_live;
    logic                do_switch;

    rr_pick u_rr_pick (
        .mask   (run_trd),
        .offset (cur_trd_q),
        .index  (pick_idx),
        .found  (any_run)
    );

    always_comb begin
        state_d     = state_q;
        cur_trd_d   = cur_trd_q;
        qcnt_d      = qcnt_q;
        lock_cnt_d  = lock_cnt_q;
        cur_vld_d   = cur_vld_q;
        atomic_to_d = atomic_to_q;
        switch_p_d  = 1'b0;
        do_switch   = 1'b0;
        cur_live    = run_trd[cur_trd_q];

        if (!stall) begin
            if (!any_run) begin
                state_d    = IDLE;
                lock_cnt_d = '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_d    = RUN;
                        cur_trd_d  = pick_idx;
                        qcnt_d     = quantum;
                        switch_p_d = 1'b1;
                    end
                    RUN: begin
                        if (!cur_live) begin
                            do_switch = 1'b1;
                        end else if (atomic) begin
                            state_d = LOCK;
                        end else if (yield || (qcnt_q == '0)) begin
                            do_switch = 1'b1;
                        end else begin
                            qcnt_d = qcnt_q - 1'b1;
                        end
                    end
                    LOCK: begin
                        // The increment that would reach ATOMIC_MAX is the timeout itself.
                        if (!cur_live) begin
                            do_switch = 1'b1;
                        end else if (lock_cnt_q == (ATOMIC_MAX - 6'd1)) begin
                            atomic_to_d = 1'b1;
                            do_switch   = 1'b1;
                        end else if (atomic) begin
                            lock_cnt_d = lock_cnt_q + 1'b1;
                        end else begin
                            state_d    = RUN;
                            lock_cnt_d = '0;
                        end
                    end
                    default: state_d = IDLE;
                endcase

                if (do_switch) begin
                    state_d    = RUN;
                    lock_cnt_d = '0;
                    cur_trd_d  = pick_idx;
                    qcnt_d     = quantum;
                    switch_p_d = (pick_idx != cur_trd_q);
                end
            end
            cur_vld_d = (state_d != IDLE) && run_trd[cur_trd_d];
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cur_trd_q   <= '0;
            qcnt_q      <= '0;
            lock_cnt_q  <= '0;
            cur_vld_q   <= 1'b0;
            switch_p_q  <= 1'b0;
            atomic_to_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_trd_q   <= cur_trd_d;
            qcnt_q      <= qcnt_d;
            lock_cnt_q  <= lock_cnt_d;
            cur_vld_q   <= cur_vld_d;
            switch_p_q  <= switch_p_d;
            atomic_to_q <= atomic_to_d;
        end
    end

    assign cur_trd   = cur_trd_q;
    assign nxt_trd   = pick_idx;
    assign cur_vld   = cur_vld_q;
    assign switch_p  = switch_p_q;
    assign atomic_to = atomic_to_q;

endmodule

// File: tb/tb_trd_sched.sv
// Self-checking bench for trd_sched: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural scheduler model.
module tb_trd_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] run_trd = 8'h00;
    logic       stall = 1'b0;
    logic       atomic = 1'b0;
    logic       yield = 1'b0;
    logic [3:0] quantum = 4'd0;
    logic [2:0] cur_trd;
    logic [2:0] nxt_trd;
    logic       cur_vld;
    logic       switch_p;
    logic       atomic_to;

    int n_chk  = 0;
    int n_fail = 0;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_LOCK = 2;

    // Model: mode, current thread, cycles left in the slice, cycles spent locked, outputs.
    int m_mode, m_cur, m_left, m_age, m_vld, m_sw, m_to;

    int exp_seq[4] = '{2, 0, 2, 0};

    trd_sched dut (
        .clk       (clk),
        .rst       (rst),
        .run_trd   (run_trd),
        .stall     (stall),
        .atomic    (atomic),
        .yield     (yield),
        .quantum   (quantum),
        .cur_trd   (cur_trd),
        .nxt_trd   (nxt_trd),
        .cur_vld   (cur_vld),
        .switch_p  (switch_p),
        .atomic_to (atomic_to)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rr(input logic [7:0] m, input int cur);
        for (int k = 1; k <= 8; k++) begin
            if (m[(cur + k) % 8]) return (cur + k) % 8;
        end
        return cur;
    endfunction

    task automatic model_step();
        int pick;
        bit switch_now;
        m_sw = 0;
        if (stall) return;
        pick = rr(run_trd, m_cur);
        switch_now = 1'b0;
        if (run_trd == 8'h00) begin
            m_mode = M_IDLE;
            m_age  = 0;
        end else if (m_mode == M_IDLE) begin
            m_mode = M_RUN;
            m_cur  = pick;
            m_left = quantum;
            m_sw   = 1;
        end else if (!run_trd[m_cur]) begin
            switch_now = 1'b1;
        end else if (m_mode == M_LOCK && m_age + 1 == 63) begin
            m_to = 1;
            switch_now = 1'b1;
        end else if (m_mode == M_LOCK) begin
            if (atomic) m_age++;
            else begin
                m_mode = M_RUN;
                m_age  = 0;
            end
        end else if (atomic) begin
            m_mode = M_LOCK;
        end else if (yield || m_left == 0) begin
            switch_now = 1'b1;
        end else begin
            m_left--;
        end
        if (switch_now) begin
            m_sw   = (pick != m_cur) ? 1 : 0;
            m_cur  = pick;
            m_left = quantum;
            m_mode = M_RUN;
            m_age  = 0;
        end
        m_vld = (m_mode != M_IDLE && run_trd[m_cur]) ? 1 : 0;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = M_IDLE; m_cur = 0; m_left = 0; m_age = 0;
            m_vld = 0; m_sw = 0; m_to = 0;
        end else begin
            model_step();
        end
    end

    always @(negedge clk) begin
        check("m_cur_trd",   cur_trd,   m_cur);
        check("m_nxt_trd",   nxt_trd,   rr(run_trd, m_cur));
        check("m_cur_vld",   cur_vld,   m_vld);
        check("m_switch_p",  switch_p,  m_sw);
        check("m_atomic_to", atomic_to, m_to);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int waited;
        #1 rst = 1'b1;
        cyc(); cyc();

        // Barrel: two threads, switch every cycle.
        rst = 1'b0; run_trd = 8'h05; quantum = 4'd0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("barrel_cur", cur_trd, exp_seq[i]);
            check("barrel_sw",  switch_p, 1);
            check("barrel_nxt", nxt_trd, exp_seq[(i + 1) % 4]);
        end
        check("barrel_vld", cur_vld, 1);

        // Quantum: four-cycle slices, then a yield on the second cycle of a slice.
        rst = 1'b1; cyc();
        rst = 1'b0; run_trd = 8'h03; quantum = 4'd3;
        for (int i = 0; i < 8; i++) begin
            cyc();
            check("qnt_cur", cur_trd, (i < 4) ? 1 : 0);
            check("qnt_sw",  switch_p, (i % 4 == 0) ? 1 : 0);
        end
        cyc(); check("qnt_back_cur", cur_trd, 1);
        cyc(); check("qnt_hold_cur", cur_trd, 1);
        yield = 1'b1;
        cyc();
        yield = 1'b0;
        check("yield_cur", cur_trd, 0);
        check("yield_sw",  switch_p, 1);
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("yield_slice_cur", cur_trd, (i < 3) ? 0 : 1);
            check("yield_slice_sw",  switch_p, (i == 3) ? 1 : 0);
        end

        // Lock: thread 1 holds the pipeline for 10 cycles, yield ignored meanwhile.
        cyc();
        atomic = 1'b1;
        for (int i = 0; i < 10; i++) begin
            yield = (i >= 3 && i <= 5);
            cyc();
            check("lock_cur", cur_trd, 1);
            check("lock_sw",  switch_p, 0);
        end
        atomic = 1'b0; yield = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("unlock_cur", cur_trd, (i < 3) ? 1 : 0);
            check("unlock_sw",  switch_p, (i == 3) ? 1 : 0);
        end

        // Kill while locked, then empty mask.
        atomic = 1'b1;
        cyc(); cyc();
        run_trd = 8'h06;
        #1 check("kill_nxt", nxt_trd, 1);
        cyc();
        check("kill_cur", cur_trd, 1);
        check("kill_sw",  switch_p, 1);
        check("kill_vld", cur_vld, 1);
        atomic = 1'b0; run_trd = 8'h00;
        #1 check("empty_nxt", nxt_trd, 1);
        cyc();
        check("empty_vld", cur_vld, 0);
        check("empty_cur", cur_trd, 1);
        check("empty_sw",  switch_p, 0);

        // Timeout: atomic held 70 cycles with a 5-cycle stall inside the lock.
        rst = 1'b1; cyc();
        rst = 1'b0; run_trd = 8'h11; quantum = 4'd5;
        for (int k = 1; k <= 72; k++) begin
            atomic = (k <= 70);
            stall  = (k >= 20 && k <= 24);
            cyc();
            if (k == 1) check("to_first_cur", cur_trd, 4);
            if (k >= 20 && k <= 24) begin
                check("to_stall_sw",  switch_p, 0);
                check("to_stall_cur", cur_trd, 4);
            end
            if (k == 69) begin
                check("to_pre_flag", atomic_to, 0);
                check("to_pre_cur",  cur_trd, 4);
            end
            if (k == 70) begin
                check("to_flag",   atomic_to, 1);
                check("to_sw_cur", cur_trd, 0);
                check("to_sw",     switch_p, 1);
            end
        end
        stall = 1'b0;

        // Reset mid-lock discards progress; first pick searches from thread 1.
        run_trd = 8'h81; quantum = 4'd1; atomic = 1'b0;
        waited = 0;
        while (cur_trd != 3'd7 && waited < 12) begin
            cyc();
            waited++;
        end
        check("reach_t7", cur_trd, 7);
        atomic = 1'b1;
        repeat (5) cyc();
        check("lock_t7", cur_trd, 7);
        rst = 1'b1;
        #1;
        check("rst_cur", cur_trd, 0);
        check("rst_vld", cur_vld, 0);
        check("rst_sw",  switch_p, 0);
        check("rst_to",  atomic_to, 0);
        check("rst_nxt", nxt_trd, 7);
        cyc();
        rst = 1'b0; atomic = 1'b0;
        cyc();
        check("post_rst_cur", cur_trd, 7);
        check("post_rst_sw",  switch_p, 1);
        check("post_rst_vld", cur_vld, 1);

        // Randomized traffic, checked by the model every cycle.
        quantum = 4'd2;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                case ($urandom_range(0, 4))
                    0:       run_trd = 8'h00;
                    1:       run_trd = 8'h01 << $urandom_range(0, 7);
                    default: run_trd = 8'($urandom);
                endcase
            end
            stall = ($urandom_range(0, 9) == 0);
            yield = ($urandom_range(0, 6) == 0);
            if ($urandom_range(0, 39) == 0) atomic = ~atomic;
            if ($urandom_range(0, 99) == 0) quantum = 4'($urandom_range(0, 15));
            rst = ($urandom_range(0, 999) == 0);
            cyc();
        end
        rst = 1'b0;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
